ads1115_scan_sequencer: RTL and testbench
=========================================

// Module: ads1115_scan_sequencer
// PURPOSE
//  Sequences a byte-level I2C master engine to scan up to 4 ADS1115 single-ended channels round-robin.
//  Per channel: write Config register, wait for conversion, set pointer to Conversion register, read 16 bits.
//  Delivers each result tagged with its channel to the display/readout path.
//  Sits between the top-level ADC wrapper and the I2C byte engine; owns the bus while run is high.
// PARAMETERS
//  DEV_ADDR   7'h48    ADS1115 7-bit slave address
//  PGA        3'b001   Config PGA field (+/-4.096 V)
//  DR         3'b100   Config data-rate field (128 SPS)
//  CONV_WAIT  1_000_000  clk cycles waited after Config write; must be >= 1
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   synchronous, active-low reset
//  run          in   1   level; high = keep scanning
//  chan_en      in   4   channel enable mask, bit n = AINn
//  cmd_valid    out  1   command to byte engine valid
//  cmd_ready    in   1   engine accepts command this cycle
//  cmd_op       out  2   00 START, 01 WRITE, 10 READ, 11 STOP
//  cmd_wdata    out  8   byte for WRITE
//  cmd_nack     out  1   for READ: 1 = master NACKs this byte (last byte)
//  rsp_valid    in   1   engine finished WRITE/READ; 1-cycle pulse
//  rsp_rdata    in   8   byte read (valid with rsp_valid)
//  rsp_nack     in   1   slave NACKed WRITE (valid with rsp_valid)
//  sample_valid out  1   1-cycle pulse: new result
//  sample_data  out 16   conversion result, two's complement, MSB first byte
//  sample_ch    out  2   channel of sample_data
//  busy         out  1   high in every state except IDLE
//  err          out  1   sticky NACK flag; cleared on run rising edge
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state IDLE, all outputs 0, ch pointer 0, wait counter 0.
//  Handshake: one command outstanding; cmd_* held stable until cmd_valid&&cmd_ready.
//   START/STOP complete on acceptance; WRITE/READ wait for rsp_valid before next command.
//  Config MSB = {1'b1, 1'b1, ch[1:0], PGA, 1'b1} (OS, single-ended MUX, single-shot).
//  Config LSB = {DR, 5'b00011} (comparator disabled).
//  States:
//   IDLE: if run && chan_en!=0 -> pick first enabled ch >= pointer (wrap 3->0) -> CFG.
//   CFG:  START, WRITE {DEV_ADDR,0}, WRITE 8'h01, WRITE MSB, WRITE LSB, STOP -> WAIT.
//   WAIT: count CONV_WAIT cycles, no commands -> PTR.
//   PTR:  START, WRITE {DEV_ADDR,0}, WRITE 8'h00, STOP -> RD.
//   RD:   START, WRITE {DEV_ADDR,1}, READ nack=0 (MSB), READ nack=1 (LSB), STOP -> DONE.
//   DONE: sample_valid=1 one cycle with data/ch; pointer = ch+1 mod 4;
//         run && chan_en!=0 -> next enabled ch -> CFG, else IDLE.
//   ABORT: any rsp_nack=1 -> set err, issue STOP, pointer = ch+1, then as DONE without sample_valid.
//  Latency: IDLE->CFG 1 cycle; DONE->CFG 1 cycle; no idle cycles between a response and the next command.
//  run low mid-scan: current channel finishes (or aborts) normally, then IDLE; never abandons bus without STOP.
//  chan_en change: sampled only when choosing the next channel; disabled current ch still completes.
//  chan_en==0 while run: remain IDLE, busy=0.
//  Reset mid-transaction: immediate IDLE, cmd_valid=0; engine shares the reset, so no STOP issued.
//  sample_data/sample_ch hold last value until next sample_valid.
//  err set and run rising edge in the same cycle: err ends at 0 (clear wins).
// STRUCTURE
//  Shared package ads1115_pkg: cmd_op encodings, register pointers 8'h00/8'h01, config field positions.
//  Sub-module ads1115_chan_picker: combinational next-enabled-channel from mask and pointer, with wrap.
//  Single FSM and step counter inside each transaction state; 20-bit-plus wait counter sized from CONV_WAIT.
// TESTING
//  1. run=1, chan_en=4'b0001, always-ready engine model -> bytes 90 01 C3 83 / 90 00 / 91 + 2 reads;
//     read 8'h12,8'h34 -> sample_data=16'h1234, sample_ch=0, one pulse.
//  2. chan_en=4'b1010 -> sample_ch sequence 1,3,1,3; Config MSB 8'hD3 then 8'hF3.
//  3. Slave NACKs address byte -> STOP issued next, err=1, no sample_valid; next channel proceeds.
//  4. run dropped during WAIT -> PTR/RD complete, one sample_valid, then IDLE with busy=0.
//  5. reset low during RD with cmd_ready random -> next cycle cmd_valid=0, busy=0, err=0.
//  6. cmd_ready held low 50 cycles -> cmd_op/cmd_wdata unchanged throughout; CONV_WAIT=10 gives exactly 10 idle cycles.

Source files
------------

// File: rtl/ads1115_pkg.sv
// Shared definitions for the ADS1115 scan sequencer: byte-engine opcodes,
// register pointers, Config field layout and sequencer states.
package ads1115_pkg;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   localparam logic [7:0] REG_CONV   = 8'h00;
   localparam logic [7:0] REG_CONFIG = 8'h01;

   localparam int CFG_OS_BIT   = 15;
   localparam int CFG_MUX_LSB  = 12;
   localparam int CFG_PGA_LSB  = 9;
   localparam int CFG_MODE_BIT = 8;
   localparam int CFG_DR_LSB   = 5;
   localparam logic [4:0] CFG_COMP_OFF = 5'b00011;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CFG, ST_WAIT, ST_PTR, ST_RD, ST_DONE, ST_ABORT
   } state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] wdata;
      logic       nack;
   } cmd_t;

   // Single-shot, single-ended AINch conversion with the comparator disabled.
   function automatic logic [15:0] config_word(input logic [1:0] ch,
                                               input logic [2:0] pga,
                                               input logic [2:0] dr);
      logic [15:0] w;
      w = '0;
      w[CFG_OS_BIT]          = 1'b1;
      w[CFG_MUX_LSB + 2]     = 1'b1;
      w[CFG_MUX_LSB +: 2]    = ch;
      w[CFG_PGA_LSB +: 3]    = pga;
      w[CFG_MODE_BIT]        = 1'b1;
      w[CFG_DR_LSB +: 3]     = dr;
      w[4:0]                 = CFG_COMP_OFF;
      return w;
   endfunction

endpackage

// File: rtl/ads1115_chan_picker.sv
// Combinational round-robin picker: first enabled channel at or after start,
// wrapping 3 -> 0. Callers only consult it with a non-zero mask.
module ads1115_chan_picker
   import ads1115_pkg::*;
(
   input  logic [3:0] mask,
   input  logic [1:0] start,
   output logic [1:0] ch
);

   // Scan from the farthest offset down so the nearest enabled channel wins.
   always_comb begin
      ch = start;
      for (int i = 3; i >= 0; i--) begin
         if (mask[start + 2'(i)]) ch = start + 2'(i);
      end
   end

endmodule

// File: rtl/ads1115_scan_sequencer.sv
// Drives a byte-level I2C engine to scan enabled ADS1115 channels round-robin:
// Config write, conversion wait, pointer set, 16-bit read, tagged result out.
module ads1115_scan_sequencer
   import ads1115_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR  = 7'h48,
   parameter logic [2:0]  PGA       = 3'b001,
   parameter logic [2:0]  DR        = 3'b100,
   parameter int unsigned CONV_WAIT = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [3:0]  chan_en,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_op,
   output logic [7:0]  cmd_wdata,
   output logic        cmd_nack,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_rdata,
   input  logic        rsp_nack,
   output logic        sample_valid,
   output logic [15:0] sample_data,
   output logic [1:0]  sample_ch,
   output logic        busy,
   output logic        err
);

   localparam int CNT_NAT = $clog2(CONV_WAIT + 1);
   localparam int CNT_W   = (CNT_NAT > 20) ? CNT_NAT : 20;

   state_t           state, state_n;
   logic [2:0]       step;
   logic             wait_rsp;
   logic [1:0]       ch, ptr, pick_start, pick_ch;
   logic [CNT_W-1:0] wait_cnt;
   logic [7:0]       rx_msb, rx_lsb;
   logic             run_q;
   cmd_t             cmd;
   logic             step_inc, issue, load_ch, chan_end, abort_set;

   function automatic cmd_t cmd_lookup(input state_t s, input logic [2:0] stp,
                                       input logic [1:0] c);
      logic [15:0] cfg;
      cmd_t        k;
      cfg     = config_word(c, PGA, DR);
      k.op    = OP_STOP;
      k.wdata = 8'h00;
      k.nack  = 1'b0;
      case (s)
         ST_CFG: case (stp)
            3'd0: k.op = OP_START;
            3'd1: begin k.op = OP_WRITE; k.wdata = {DEV_ADDR, 1'b0}; end
            3'd2: begin k.op = OP_WRITE; k.wdata = REG_CONFIG; end
            3'd3: begin k.op = OP_WRITE; k.wdata = cfg[15:8]; end
            3'd4: begin k.op = OP_WRITE; k.wdata = cfg[7:0]; end
            default: ;
         endcase
         ST_PTR: case (stp)
            3'd0: k.op = OP_START;
            3'd1: begin k.op = OP_WRITE; k.wdata = {DEV_ADDR, 1'b0}; end
            3'd2: begin k.op = OP_WRITE; k.wdata = REG_CONV; end
            default: ;
         endcase
         ST_RD: case (stp)
            3'd0: k.op = OP_START;
            3'd1: begin k.op = OP_WRITE; k.wdata = {DEV_ADDR, 1'b1}; end
            3'd2: k.op = OP_READ;
            3'd3: begin k.op = OP_READ; k.nack = 1'b1; end
            default: ;
         endcase
         default: ;
      endcase
      return k;
   endfunction

   // Leaving IDLE resumes from the stored pointer; otherwise continue after ch.
   assign pick_start = (state == ST_IDLE) ? ptr : ch + 2'd1;

   ads1115_chan_picker u_picker (
      .mask  (chan_en),
      .start (pick_start),
      .ch    (pick_ch)
   );

   always_comb begin
      state_n   = state;
      cmd       = cmd_lookup(state, step, ch);
      cmd_valid = 1'b0;
      step_inc  = 1'b0;
      issue     = 1'b0;
      load_ch   = 1'b0;
      chan_end  = 1'b0;
      abort_set = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run && |chan_en) begin
               state_n = ST_CFG;
               load_ch = 1'b1;
            end
         end
         ST_CFG, ST_PTR, ST_RD: begin
            if (wait_rsp) begin
               if (rsp_valid) begin
                  if (rsp_nack) begin
                     state_n   = ST_ABORT;
                     abort_set = 1'b1;
                  end else begin
                     step_inc = 1'b1;
                  end
               end
            end else begin
               cmd_valid = 1'b1;
               if (cmd_ready) begin
                  case (cmd.op)
                     OP_START: step_inc = 1'b1;
                     OP_STOP:  state_n  = (state == ST_CFG) ? ST_WAIT :
                                          (state == ST_PTR) ? ST_RD : ST_DONE;
                     default:  issue    = 1'b1;
                  endcase
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == CNT_W'(CONV_WAIT - 1)) state_n = ST_PTR;
         end
         ST_DONE, ST_ABORT: begin
            cmd_valid = (state == ST_ABORT);
            if (state == ST_DONE || cmd_ready) begin
               chan_end = 1'b1;
               if (run && |chan_en) begin
                  state_n = ST_CFG;
                  load_ch = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
      cmd_op    = cmd_valid ? cmd.op    : OP_START;
      cmd_wdata = cmd_valid ? cmd.wdata : 8'h00;
      cmd_nack  = cmd_valid ? cmd.nack  : 1'b0;
   end

   assign sample_valid = (state == ST_DONE);
   assign busy         = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         step        <= 3'd0;
         wait_rsp    <= 1'b0;
         ch          <= 2'd0;
         ptr         <= 2'd0;
         wait_cnt    <= '0;
         run_q       <= 1'b0;
         err         <= 1'b0;
         sample_data <= 16'h0000;
         sample_ch   <= 2'd0;
      end else begin
         run_q    <= run;
         step     <= (state_n != state) ? 3'd0 : step + {2'b00, step_inc};
         wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
         if (state_n != state)          wait_rsp <= 1'b0;
         else if (issue)                wait_rsp <= 1'b1;
         else if (wait_rsp && rsp_valid) wait_rsp <= 1'b0;
         if (load_ch)  ch  <= pick_ch;
         if (chan_end) ptr <= ch + 2'd1;
         // A fresh run request clears the sticky flag even if a NACK lands now.
         if (run && !run_q)  err <= 1'b0;
         else if (abort_set) err <= 1'b1;
         if (state == ST_RD && state_n == ST_DONE) begin
            sample_data <= {rx_msb, rx_lsb};
            sample_ch   <= ch;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_RD && wait_rsp && rsp_valid) begin
         if (step == 3'd2) rx_msb <= rsp_rdata;
         if (step == 3'd3) rx_lsb <= rsp_rdata;
      end
   end

endmodule

// File: tb/tb_ads1115_scan_sequencer.sv
// Directed bench for ads1115_scan_sequencer with a behavioural byte-engine model
// that logs every accepted command and every result pulse.
module tb_ads1115_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset, run;
   logic [3:0]  chan_en;
   logic        cmd_valid, cmd_ready, cmd_nack;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid, rsp_nack;
   logic [7:0]  rsp_rdata;
   logic        sample_valid, busy, err;
   logic [15:0] sample_data;
   logic [1:0]  sample_ch;

   int checks = 0;
   int failures = 0;

   // Controls written only by the main sequence.
   bit         rnd_ready = 1'b0;
   int         stall_at  = -1;
   int         stall_len = 0;
   int         nack_req  = 0;
   logic [7:0] rd_data [64];
   int         rd_wr     = 0;

   // State written only by the engine model.
   logic [1:0] log_op  [$];
   logic [7:0] log_wd  [$];
   logic       log_nk  [$];
   int         log_cyc [$];
   logic [15:0] smp_d  [$];
   logic [1:0]  smp_c  [$];
   int         cyc = 0;

   always #5 clk = ~clk;

   ads1115_scan_sequencer #(.CONV_WAIT(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .chan_en      (chan_en),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_wdata    (cmd_wdata),
      .cmd_nack     (cmd_nack),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_nack     (rsp_nack),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ch    (sample_ch),
      .busy         (busy),
      .err          (err)
   );

   // Byte engine: responds to WRITE/READ one cycle after acceptance.
   initial begin : engine
      bit         pend;
      logic       pend_nack;
      logic [7:0] pend_data;
      int         rd_rd, nack_served, stall_cnt;
      pend = 0; pend_nack = 0; pend_data = 0;
      rd_rd = 0; nack_served = 0; stall_cnt = 0;
      cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0;
      forever begin
         @(negedge clk);
         cyc++;
         rsp_valid = 0;
         rsp_nack  = 0;
         if (sample_valid) begin
            smp_d.push_back(sample_data);
            smp_c.push_back(sample_ch);
         end
         if (!reset) begin
            pend = 0;
            cmd_ready = 0;
         end else if (pend) begin
            pend = 0;
            cmd_ready = 0;
            rsp_valid = 1;
            rsp_nack  = pend_nack;
            rsp_rdata = pend_data;
         end else begin
            if (log_op.size() == stall_at && stall_cnt < stall_len) begin
               cmd_ready = 0;
               stall_cnt++;
            end else if (rnd_ready) begin
               cmd_ready = 1'($urandom_range(0, 1));
            end else begin
               cmd_ready = 1;
            end
            if (cmd_valid && cmd_ready) begin
               log_op.push_back(cmd_op);
               log_wd.push_back(cmd_wdata);
               log_nk.push_back(cmd_nack);
               log_cyc.push_back(cyc);
               if (cmd_op == 2'b01) begin
                  pend = 1;
                  pend_data = 8'h00;
                  pend_nack = (nack_served < nack_req) && (cmd_wdata == 8'h90);
                  if (pend_nack) nack_served++;
               end else if (cmd_op == 2'b10) begin
                  pend = 1;
                  pend_nack = 0;
                  pend_data = (rd_rd < rd_wr) ? rd_data[rd_rd] : 8'h00;
                  rd_rd++;
               end
            end
         end
      end
   end

   task automatic push_rd(input logic [7:0] b);
      rd_data[rd_wr] = b;
      rd_wr++;
   endtask

   task automatic wait_pulses(input int n, input int limit, output bit ok);
      int seen = 0;
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (sample_valid) seen++;
         if (seen == n) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_log(input int target, input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (log_op.size() >= target) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 0; run = 0; chan_en = 4'b0000;
      repeat (3) @(negedge clk);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
      checks++; if ({cmd_op, cmd_wdata, cmd_nack} !== 11'd0) begin failures++; $display("FAIL reset_cmd_fields got=%h exp=0", {cmd_op, cmd_wdata, cmd_nack}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sample_valid got=%b exp=0", sample_valid); end
      checks++; if ({sample_data, sample_ch} !== 18'd0) begin failures++; $display("FAIL reset_sample got=%h exp=0", {sample_data, sample_ch}); end
      reset = 1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_run_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      logic [1:0] eop [15] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd1, 2'd1, 2'd3,
                               2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
      logic [7:0] ewd [15] = '{8'h00, 8'h90, 8'h01, 8'hC3, 8'h83, 8'h00, 8'h00, 8'h90, 8'h00,
                               8'h00, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00};
      int base, sb;
      bit ok;
      chan_en = 4'b0001;
      push_rd(8'h12); push_rd(8'h34);
      base = log_op.size(); sb = smp_d.size();
      run = 1;
      @(negedge clk);
      checks++; if ({cmd_valid, cmd_op} !== 3'b100) begin failures++; $display("FAIL idle_to_cfg_start got=%b exp=100", {cmd_valid, cmd_op}); end
      wait_pulses(1, 400, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=0 exp=1"); end
      run = 0;
      repeat (5) @(negedge clk);
      checks++; if (log_op.size() - base !== 15) begin failures++; $display("FAIL single_cmd_count got=%0d exp=15", log_op.size() - base); end
      if (log_op.size() >= base + 15) begin
         for (int i = 0; i < 15; i++) begin
            checks++; if (log_op[base+i] !== eop[i]) begin failures++; $display("FAIL single_op[%0d] got=%0d exp=%0d", i, log_op[base+i], eop[i]); end
            if (eop[i] == 2'd1) begin
               checks++; if (log_wd[base+i] !== ewd[i]) begin failures++; $display("FAIL single_wdata[%0d] got=%h exp=%h", i, log_wd[base+i], ewd[i]); end
            end
            if (eop[i] == 2'd2) begin
               checks++; if (log_nk[base+i] !== (i == 13)) begin failures++; $display("FAIL single_rd_nack[%0d] got=%b exp=%b", i, log_nk[base+i], i == 13); end
            end
         end
         checks++; if (log_cyc[base+2] - log_cyc[base+1] !== 2) begin failures++; $display("FAIL rsp_to_next_cmd got=%0d exp=2", log_cyc[base+2] - log_cyc[base+1]); end
         checks++; if (log_cyc[base+6] - log_cyc[base+5] !== 11) begin failures++; $display("FAIL conv_wait_gap got=%0d exp=11", log_cyc[base+6] - log_cyc[base+5]); end
      end
      checks++; if (smp_d.size() - sb !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", smp_d.size() - sb); end
      if (smp_d.size() > sb) begin
         checks++; if ({smp_d[sb], smp_c[sb]} !== {16'h1234, 2'd0}) begin failures++; $display("FAIL single_sample got=%h/%0d exp=1234/0", smp_d[sb], smp_c[sb]); end
      end
      checks++; if (sample_data !== 16'h1234) begin failures++; $display("FAIL single_hold got=%h exp=1234", sample_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_two_chan();
      logic [1:0]  ech [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
      logic [15:0] edat [4] = '{16'hA101, 16'hB303, 16'hC102, 16'hD304};
      int base, sb;
      bit ok;
      chan_en = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         push_rd(edat[k][15:8]); push_rd(edat[k][7:0]);
      end
      base = log_op.size(); sb = smp_d.size();
      run = 1;
      wait_pulses(4, 800, ok);
      checks++; if (!ok) begin failures++; $display("FAIL two_chan_timeout got=0 exp=1"); end
      run = 0;
      repeat (5) @(negedge clk);
      checks++; if (smp_d.size() - sb !== 4) begin failures++; $display("FAIL two_chan_pulses got=%0d exp=4", smp_d.size() - sb); end
      if (smp_d.size() >= sb + 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (smp_c[sb+k] !== ech[k]) begin failures++; $display("FAIL two_chan_ch[%0d] got=%0d exp=%0d", k, smp_c[sb+k], ech[k]); end
            checks++; if (smp_d[sb+k] !== edat[k]) begin failures++; $display("FAIL two_chan_data[%0d] got=%h exp=%h", k, smp_d[sb+k], edat[k]); end
         end
      end
      if (log_op.size() >= base + 60) begin
         checks++; if (log_wd[base+3] !== 8'hD3) begin failures++; $display("FAIL cfg_msb_ch1 got=%h exp=D3", log_wd[base+3]); end
         checks++; if (log_wd[base+18] !== 8'hF3) begin failures++; $display("FAIL cfg_msb_ch3 got=%h exp=F3", log_wd[base+18]); end
      end else begin
         checks++; failures++; $display("FAIL two_chan_cmd_count got=%0d exp=60", log_op.size() - base);
      end
   endtask

   task automatic test_nack();
      int base, sb;
      bit ok;
      chan_en = 4'b0011;
      nack_req++;
      push_rd(8'h5A); push_rd(8'hA5);
      base = log_op.size(); sb = smp_d.size();
      run = 1;
      wait_pulses(1, 400, ok);
      checks++; if (!ok) begin failures++; $display("FAIL nack_timeout got=0 exp=1"); end
      run = 0;
      repeat (5) @(negedge clk);
      if (log_op.size() >= base + 7) begin
         checks++; if ({log_op[base+1], log_wd[base+1]} !== {2'd1, 8'h90}) begin failures++; $display("FAIL nack_addr_cmd got=%h exp=190", {log_op[base+1], log_wd[base+1]}); end
         checks++; if (log_op[base+2] !== 2'd3) begin failures++; $display("FAIL nack_stop got=%0d exp=3", log_op[base+2]); end
         checks++; if (log_cyc[base+2] - log_cyc[base+1] !== 2) begin failures++; $display("FAIL nack_stop_gap got=%0d exp=2", log_cyc[base+2] - log_cyc[base+1]); end
         checks++; if (log_op[base+3] !== 2'd0) begin failures++; $display("FAIL nack_next_start got=%0d exp=0", log_op[base+3]); end
         checks++; if (log_wd[base+6] !== 8'hD3) begin failures++; $display("FAIL nack_next_cfg got=%h exp=D3", log_wd[base+6]); end
      end else begin
         checks++; failures++; $display("FAIL nack_cmd_count got=%0d exp>=7", log_op.size() - base);
      end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL nack_err got=%b exp=1", err); end
      checks++; if (smp_d.size() - sb !== 1) begin failures++; $display("FAIL nack_pulses got=%0d exp=1", smp_d.size() - sb); end
      if (smp_d.size() > sb) begin
         checks++; if ({smp_d[sb], smp_c[sb]} !== {16'h5AA5, 2'd1}) begin failures++; $display("FAIL nack_sample got=%h/%0d exp=5AA5/1", smp_d[sb], smp_c[sb]); end
      end
   endtask

   task automatic test_run_drop();
      int base, sb;
      bit ok;
      chan_en = 4'b0100;
      push_rd(8'h77); push_rd(8'h88);
      base = log_op.size(); sb = smp_d.size();
      run = 1;
      @(negedge clk);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear_on_run got=%b exp=0", err); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%b exp=1", busy); end
      wait_log(base + 6, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL run_drop_cfg_timeout got=0 exp=1"); end
      run = 0;
      wait_pulses(1, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL run_drop_sample_timeout got=0 exp=1"); end
      repeat (20) @(negedge clk);
      checks++; if (log_op.size() - base !== 15) begin failures++; $display("FAIL run_drop_cmd_count got=%0d exp=15", log_op.size() - base); end
      if (log_op.size() > base) begin
         checks++; if (log_op[log_op.size()-1] !== 2'd3) begin failures++; $display("FAIL run_drop_last_stop got=%0d exp=3", log_op[log_op.size()-1]); end
      end
      checks++; if (smp_d.size() - sb !== 1) begin failures++; $display("FAIL run_drop_pulses got=%0d exp=1", smp_d.size() - sb); end
      checks++; if ({sample_data, sample_ch} !== {16'h7788, 2'd2}) begin failures++; $display("FAIL run_drop_sample got=%h/%0d exp=7788/2", sample_data, sample_ch); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_drop_busy got=%b exp=0", busy); end
   endtask

   task automatic test_ready_stall();
      int base, sb, changes;
      bit ok;
      chan_en = 4'b0001;
      push_rd(8'h0F); push_rd(8'hF0);
      base = log_op.size(); sb = smp_d.size();
      stall_at = base + 1; stall_len = 60;
      run = 1;
      wait_log(base + 1, 50, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_start_timeout got=0 exp=1"); end
      changes = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ({cmd_valid, cmd_op, cmd_wdata} !== {1'b1, 2'd1, 8'h90}) changes++;
      end
      checks++; if (changes !== 0) begin failures++; $display("FAIL stall_hold got=%0d changed cycles exp=0", changes); end
      checks++; if (log_op.size() - base !== 1) begin failures++; $display("FAIL stall_accepts got=%0d exp=1", log_op.size() - base); end
      wait_pulses(1, 400, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_sample_timeout got=0 exp=1"); end
      run = 0;
      repeat (5) @(negedge clk);
      checks++; if ({sample_data, sample_ch} !== {16'h0FF0, 2'd0}) begin failures++; $display("FAIL stall_sample got=%h/%0d exp=0FF0/0", sample_data, sample_ch); end
   endtask

   task automatic test_reset_mid();
      int base;
      bit ok;
      rnd_ready = 1;
      chan_en = 4'b0001;
      push_rd(8'h44); push_rd(8'h55);
      base = log_op.size();
      run = 1;
      wait_log(base + 12, 600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL reset_mid_reach_rd got=0 exp=1"); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_mid_busy_before got=%b exp=1", busy); end
      reset = 0;
      @(negedge clk);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_cmd_valid got=%b exp=0", cmd_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_mid_err got=%b exp=0", err); end
      checks++; if ({sample_valid, sample_data} !== 17'd0) begin failures++; $display("FAIL reset_mid_sample got=%h exp=0", {sample_valid, sample_data}); end
      run = 0;
      reset = 1;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_stays_idle got=%b exp=0", busy); end
   endtask

   initial begin
      reset = 0; run = 0; chan_en = 4'b0000;
      test_reset();
      test_single();
      test_two_chan();
      test_nack();
      test_run_drop();
      test_ready_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
